fb_write_arbiter: RTL and testbench

//  Shares the framebuffer RAM write port between two writers: requester 0 is the
//  ROM->RAM copier and requester 1 is the image-processing engine. Round-robin

---
 rtl/fb_pkg.sv | 13 +
 rtl/arb_rr2.sv | 13 +
 rtl/fb_write_arbiter.sv | 108 ++++++++++
 tb/tb_fb_write_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer constants shared by the arbiter, VGA read side and ROM copier.
package fb_pkg;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int IMG_W     = 160;
    localparam int IMG_H     = 120;
    localparam int N_PIX     = IMG_W * IMG_H;
    localparam int MAX_BURST = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick: ptr breaks ties, a lone request always wins.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic valid,
    output logic winner
);
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ptr : req1;
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer RAM write-port arbiter: copier (0) vs image engine (1), round-robin
// with burst locking, registered write path and out-of-range beat suppression.
module fb_write_arbiter #(
    parameter int ADDR_W    = fb_pkg::ADDR_W,
    parameter int DATA_W    = fb_pkg::DATA_W,
    parameter int N_PIX     = fb_pkg::N_PIX,
    parameter int MAX_BURST = fb_pkg::MAX_BURST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    output logic              gnt1,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              err_oob
);
    import fb_pkg::IDLE;
    import fb_pkg::OWN0;
    import fb_pkg::OWN1;

    localparam int                CNT_W     = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BURST - 1);
    localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(N_PIX);

    logic [1:0]        state, state_nxt;
    logic              ptr, ptr_nxt;
    logic [CNT_W-1:0]  beat_cnt;

    logic              owning, own_id;
    logic              cur_req, cur_last;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              accept, burst_end, in_range;
    logic              pick_ptr, pick_valid, pick;

    always_comb begin
        owning    = (state == OWN0) || (state == OWN1);
        own_id    = (state == OWN1);
        cur_req   = own_id ? req1  : req0;
        cur_addr  = own_id ? addr1 : addr0;
        cur_data  = own_id ? data1 : data0;
        cur_last  = own_id ? last1 : last0;
        accept    = owning & cur_req;
        burst_end = owning & (~cur_req | cur_last | (beat_cnt == CNT_LAST));
        in_range  = cur_addr < PIX_LIMIT;
        // While owning, pointing the picker at the other side yields the
        // handover rule: other requester first, else the current one if still asking.
        pick_ptr  = owning ? ~own_id : ptr;
    end

    arb_rr2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .ptr    (pick_ptr),
        .valid  (pick_valid),
        .winner (pick)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (!owning) begin
            if (pick_valid) state_nxt = pick ? OWN1 : OWN0;
        end else if (burst_end) begin
            ptr_nxt   = ~own_id;
            state_nxt = pick_valid ? (pick ? OWN1 : OWN0) : IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            beat_cnt   <= '0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_data   <= '0;
            err_oob    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            ram_wren <= accept & in_range;
            if (burst_end)   beat_cnt <= '0;
            else if (accept) beat_cnt <= beat_cnt + 1'b1;
            if (accept) begin
                ram_wraddr <= cur_addr;
                ram_data   <= cur_data;
            end
            if (accept && !in_range) err_oob <= 1'b1;
        end
    end

    always_comb begin
        gnt0 = (state == OWN0);
        gnt1 = (state == OWN1);
        busy = gnt0 | gnt1;
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: per-cycle model plus directed write-log checks.
module tb_fb_write_arbiter;
    typedef struct {
        logic [18:0] addr;
        logic        last;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
    logic [18:0] addr0 = '0, addr1 = '0;
    logic [7:0]  data0 = '0, data1 = '0;
    logic        gnt0, gnt1, ram_wren, busy, err_oob;
    logic [18:0] ram_wraddr;
    logic [7:0]  ram_data;

    fb_write_arbiter #(.ADDR_W(19), .DATA_W(8), .N_PIX(19200), .MAX_BURST(16)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .last0(last0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .last1(last1), .gnt1(gnt1),
        .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .err_oob(err_oob)
    );

    always #20 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit gp0 = 0, gp1 = 0;
    beat_t q0[$], q1[$];
    int log_addr[$], log_data[$], log_cyc[$];
    int exp_addr[$], exp_id[$];

    function automatic logic [7:0] data_of(input int id, input logic [18:0] a);
        return a[7:0] ^ ((id == 1) ? 8'hA5 : 8'h00);
    endfunction

    // Reference model: owner -1 means idle; beats counted 1..16 within a grant.
    int          m_own;
    int          m_cnt;
    bit          m_ptr, m_wren, m_err;
    logic [18:0] m_wa;
    logic [7:0]  m_wd;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_own <= -1; m_cnt <= 0; m_ptr <= 0;
            m_wren <= 0; m_wa <= '0; m_wd <= '0; m_err <= 0;
        end else begin : step
            int          own_n, cnt_n;
            bit          ptr_n, r, l, other, done;
            logic [18:0] a;
            own_n = m_own; cnt_n = m_cnt; ptr_n = m_ptr;
            m_wren <= 0;
            if (m_own < 0) begin
                if (req0 && req1) own_n = m_ptr;
                else if (req0)    own_n = 0;
                else if (req1)    own_n = 1;
            end else begin
                r     = (m_own == 0) ? req0 : req1;
                l     = (m_own == 0) ? last0 : last1;
                a     = (m_own == 0) ? addr0 : addr1;
                other = (m_own == 0) ? req1 : req0;
                done  = 0;
                if (r) begin
                    m_wa   <= a;
                    m_wd   <= (m_own == 0) ? data0 : data1;
                    m_wren <= (int'(a) < 19200);
                    if (int'(a) >= 19200) m_err <= 1;
                    cnt_n = m_cnt + 1;
                    if (l || cnt_n == 16) done = 1;
                end else begin
                    done = 1;
                end
                if (done) begin
                    cnt_n = 0;
                    ptr_n = (m_own == 0);
                    if (other)  own_n = 1 - m_own;
                    else if (r) own_n = m_own;
                    else        own_n = -1;
                end
            end
            m_own <= own_n; m_cnt <= cnt_n; m_ptr <= ptr_n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        req0  = (q0.size() > 0);
        addr0 = req0 ? q0[0].addr : '0;
        last0 = req0 ? q0[0].last : 1'b0;
        data0 = data_of(0, addr0);
        req1  = (q1.size() > 0);
        addr1 = req1 ? q1[0].addr : '0;
        last1 = req1 ? q1[0].last : 1'b0;
        data1 = data_of(1, addr1);
    endtask

    task automatic tick();
        @(negedge clock);
        if (reset) begin
            check("gnt0", gnt0, m_own == 0);
            check("gnt1", gnt1, m_own == 1);
            check("busy", busy, m_own >= 0);
            check("wren", ram_wren, m_wren);
            check("err_oob", err_oob, m_err);
            check("exclusive", gnt0 & gnt1, 0);
            if (m_wren) begin
                check("wraddr", ram_wraddr, m_wa);
                check("wdata", ram_data, m_wd);
            end
            if (ram_wren) begin
                log_addr.push_back(int'(ram_wraddr));
                log_data.push_back(int'(ram_data));
                log_cyc.push_back(cyc);
            end
        end
        if (gp0 && req0 && q0.size() > 0) void'(q0.pop_front());
        if (gp1 && req1 && q1.size() > 0) void'(q1.pop_front());
        drive();
        gp0 = gnt0;
        gp1 = gnt1;
        cyc++;
    endtask

    task automatic push(input int id, input int a, input bit last);
        beat_t b;
        b.addr = 19'(a);
        b.last = last;
        if (id == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || gnt0 || gnt1) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
        tick();
        tick();
    endtask

    task automatic expect_beat(input int id, input int a);
        exp_id.push_back(id);
        exp_addr.push_back(a);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, log_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            check({tag, "_addr"}, log_addr[i], exp_addr[i]);
            check({tag, "_data"}, log_data[i], data_of(exp_id[i], 19'(exp_addr[i])));
        end
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        exp_addr.delete(); exp_id.delete();
    endtask

    task automatic async_reset();
        #7 reset = 1'b0;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_oob, 0);
        q0.delete(); q1.delete();
        drive();
        gp0 = 0; gp1 = 0;
        tick();
        tick();
        reset = 1'b1;
        clear_logs();
    endtask

    initial begin
        int c_push;
        drive();
        tick();
        tick();
        check("reset_gnt0", gnt0, 0);
        check("reset_gnt1", gnt1, 0);
        check("reset_wren", ram_wren, 0);
        check("reset_wraddr", ram_wraddr, 0);
        check("reset_data", ram_data, 0);
        check("reset_err", err_oob, 0);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        tick();

        // 1: single requester, 5-beat burst
        for (int i = 0; i < 5; i++) begin push(0, i, i == 4); expect_beat(0, i); end
        drive();
        c_push = cyc;
        tick();
        check("t1_grant_latency", gnt0, 1);
        drain(50);
        check("t1_idle_after", busy, 0);
        compare_log("t1");
        if (log_cyc.size() == 5) begin
            check("t1_first_write_cycle", log_cyc[0], c_push + 1);
            for (int i = 1; i < 5; i++) check("t1_consecutive", log_cyc[i], log_cyc[0] + i);
        end

        // 2: simultaneous requests after reset, ptr=0 wins, no bubble at handover
        async_reset();
        for (int i = 0; i < 3; i++) begin push(0, 100 + i, i == 2); expect_beat(0, 100 + i); end
        for (int i = 0; i < 2; i++) begin push(1, 200 + i, i == 1); expect_beat(1, 200 + i); end
        drive();
        tick();
        check("t2_own0_first", gnt0, 1);
        drain(50);
        compare_log("t2");
        if (log_cyc.size() == 5) check("t2_no_bubble", log_cyc[4] - log_cyc[0], 4);
        clear_logs();

        // 3: both stream without last, forced re-arbitration every 16 beats
        for (int i = 0; i < 40; i++) begin push(0, 1000 + i, 0); push(1, 2000 + i, 0); end
        for (int i = 0;  i < 16; i++) expect_beat(0, 1000 + i);
        for (int i = 0;  i < 16; i++) expect_beat(1, 2000 + i);
        for (int i = 16; i < 32; i++) expect_beat(0, 1000 + i);
        for (int i = 16; i < 32; i++) expect_beat(1, 2000 + i);
        for (int i = 32; i < 40; i++) expect_beat(0, 1000 + i);
        for (int i = 32; i < 40; i++) expect_beat(1, 2000 + i);
        drive();
        drain(300);
        compare_log("t3");
        if (log_cyc.size() == 80) begin
            check("t3_cap_handover_no_bubble", log_cyc[16] - log_cyc[15], 1);
            check("t3_withdraw_gap", log_cyc[72] - log_cyc[71], 2);
        end
        clear_logs();

        // 4: out-of-range beat is consumed but not written; err_oob sticks
        check("t4_err_before", err_oob, 0);
        push(1, 19200, 0);
        push(1, 19199, 1);
        expect_beat(1, 19199);
        drive();
        drain(50);
        compare_log("t4");
        check("t4_err_sticky", err_oob, 1);
        clear_logs();

        // 5: requester 0 withdraws after 3 beats while requester 1 waits
        for (int i = 0; i < 3; i++) begin push(0, 300 + i, 0); expect_beat(0, 300 + i); end
        for (int i = 0; i < 2; i++) begin push(1, 400 + i, i == 1); expect_beat(1, 400 + i); end
        drive();
        drain(50);
        compare_log("t5");
        if (log_cyc.size() == 5) check("t5_handover_gap", log_cyc[3] - log_cyc[2], 2);
        check("t5_err_still_set", err_oob, 1);
        clear_logs();

        // 6: asynchronous reset in the middle of a burst
        for (int i = 0; i < 10; i++) push(0, 500 + i, i == 9);
        drive();
        repeat (4) tick();
        check("t6_midburst_granted", gnt0, 1);
        async_reset();
        push(0, 600, 1);
        push(1, 700, 1);
        expect_beat(0, 600);
        expect_beat(1, 700);
        drive();
        tick();
        check("t6_ptr_cleared_gnt0", gnt0, 1);
        check("t6_ptr_cleared_gnt1", gnt1, 0);
        drain(50);
        compare_log("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
